// File: rtl/frame_config_pkg.sv
// Shared definitions for the frame configuration controller: FSM states,
// header sync byte and header field positions.
package frame_config_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    GAP
  } state_e;

  localparam logic [7:0] SYNC = 8'hA5;

  // Header layout: [31:24] sync, [15:8] column, [4:0] frame index.
  localparam int SYNC_LSB = 24;
  localparam int SYNC_W   = 8;
  localparam int COL_LSB  = 8;
  localparam int COL_W    = 8;
  localparam int IDX_LSB  = 0;
  localparam int IDX_W    = 5;

  function automatic logic header_ok(
    input logic [SYNC_W-1:0] sync,
    input logic [COL_W-1:0]  col,
    input logic [IDX_W-1:0]  idx,
    input int                num_cols,
    input int                max_frames
  );
    return (sync == SYNC) && (int'(col) < num_cols) && (int'(idx) < max_frames);
  endfunction

endpackage

// File: rtl/frame_strobe_gen.sv
// Drives a single FrameStrobe line, selected by column and frame index,
// for StrobeLen cycles after a start request.
module frame_strobe_gen
  import frame_config_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int NumCols         = 4,
  parameter int StrobeLen       = 2
) (
  input  logic                                UserCLK,
  input  logic                                reset,
  input  logic                                start,
  input  logic [COL_W-1:0]                    col,
  input  logic [IDX_W-1:0]                    idx,
  output logic [NumCols*MaxFramesPerCol-1:0]  strobe,
  output logic                                last
);

  localparam int NumStrobes = NumCols * MaxFramesPerCol;

  logic [NumStrobes-1:0] onehot;
  logic [31:0]           sel;
  logic [3:0]            hold_cnt;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sel    = 32'(col) * 32'(MaxFramesPerCol) + 32'(idx);
    onehot = '0;
    for (int i = 0; i < NumStrobes; i++) begin
      onehot[i] = (sel == 32'(i));
    end
  end

  // hold_cnt counts the remaining high cycles after the current one.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      strobe   <= '0;
      hold_cnt <= '0;
    end else if (start) begin
      strobe   <= onehot;
      hold_cnt <= 4'(StrobeLen - 1);
    end else if (hold_cnt != 4'd0) begin
      hold_cnt <= hold_cnt - 4'd1;
    end else begin
      strobe   <= '0;
    end
  end

  assign last = (strobe != '0) && (hold_cnt == 4'd0);

endmodule

// File: rtl/frame_config_ctrl.sv
// Frame configuration controller: takes a header plus NumRows data words from
// a valid/ready stream, presents them on FrameData and strobes one frame line.
module frame_config_ctrl
  import frame_config_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4,
  parameter int NumCols         = 4,
  parameter int StrobeLen       = 2
) (
  input  logic                                UserCLK,
  input  logic                                reset,
  input  logic [FrameBitsPerRow-1:0]          s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                busy,
  output logic                                err,
  output logic [15:0]                         frames_done
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  state_e           state;
  logic [RowW-1:0]  row_cnt;
  logic [COL_W-1:0] col_q;
  logic [IDX_W-1:0] idx_q;
  logic             xfer;
  logic             hdr_valid;
  logic             start;
  logic             strobe_last;

  assign xfer      = s_valid & s_ready;
  assign hdr_valid = header_ok(s_data[SYNC_LSB +: SYNC_W], s_data[COL_LSB +: COL_W],
                               s_data[IDX_LSB +: IDX_W], NumCols, MaxFramesPerCol);
  assign start     = (state == LOAD) && xfer && (row_cnt == LastRow);

  // s_ready is a register, so it never depends on s_valid in the same cycle.
  // NOTE: state is written with non-blocking assignments only, so every
  // register samples pre-edge values and block order cannot change behaviour.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      frames_done <= '0;
      row_cnt     <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      // NOTE: the frame data register is reset on purpose: a partially
      // loaded frame must never stay visible on FrameData after reset.
      FrameData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (xfer) begin
            if (hdr_valid) begin
              state   <= LOAD;
              busy    <= 1'b1;
              row_cnt <= '0;
              col_q   <= s_data[COL_LSB +: COL_W];
              idx_q   <= s_data[IDX_LSB +: IDX_W];
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            for (int r = 0; r < NumRows; r++) begin
              if (row_cnt == RowW'(r)) begin
                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
              end
            end
            row_cnt <= row_cnt + RowW'(1);
            if (row_cnt == LastRow) begin
              state   <= STROBE;
              s_ready <= 1'b0;
            end
          end
        end
        STROBE: begin
          if (strobe_last) begin
            state <= GAP;
          end
        end
        GAP: begin
          frames_done <= frames_done + 16'd1;
          state       <= IDLE;
          s_ready     <= 1'b1;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  frame_strobe_gen #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumCols         (NumCols),
    .StrobeLen       (StrobeLen)
  ) u_strobe_gen (
    .UserCLK (UserCLK),
    .reset   (reset),
    .start   (start),
    .col     (col_q),
    .idx     (idx_q),
    .strobe  (FrameStrobe),
    .last    (strobe_last)
  );

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Self-checking bench for frame_config_ctrl: directed and randomized frames
// against a frame-level reference model, plus a frame counter wrap run.
module tb_frame_config_ctrl;

  localparam int W  = 32;
  localparam int MF = 20;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SL = 2;

  logic              UserCLK = 1'b0;
  logic              reset   = 1'b1;
  logic [W-1:0]      s_data  = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [NR*W-1:0]   frame_data;
  logic [NC*MF-1:0]  frame_strobe;
  logic              busy;
  logic              err;
  logic [15:0]       frames_done;

  // Small instance used for the frame counter wrap run.
  logic [W-1:0]      m_data  = '0;
  logic              m_valid = 1'b0;
  logic              m_ready;
  logic [W-1:0]      m_fd;
  logic [7:0]        m_strobe;
  logic              m_busy;
  logic              m_err;
  logic [15:0]       m_frames_done;

  int checks = 0;
  int errors = 0;
  int m_strobe_cycles = 0;
  bit strobe_window = 1'b0;

  // Reference model: last committed frame, frame count, sticky error.
  logic [NR*W-1:0] model_fd = '0;
  int              model_frames = 0;
  bit              model_err = 1'b0;

  always #5 UserCLK = ~UserCLK;

  frame_config_ctrl #(
    .FrameBitsPerRow (W),
    .MaxFramesPerCol (MF),
    .NumRows         (NR),
    .NumCols         (NC),
    .StrobeLen       (SL)
  ) dut (
    .UserCLK     (UserCLK),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (frame_data),
    .FrameStrobe (frame_strobe),
    .busy        (busy),
    .err         (err),
    .frames_done (frames_done)
  );

  frame_config_ctrl #(
    .FrameBitsPerRow (W),
    .MaxFramesPerCol (4),
    .NumRows         (1),
    .NumCols         (2),
    .StrobeLen       (1)
  ) dut_mini (
    .UserCLK     (UserCLK),
    .reset       (reset),
    .s_data      (m_data),
    .s_valid     (m_valid),
    .s_ready     (m_ready),
    .FrameData   (m_fd),
    .FrameStrobe (m_strobe),
    .busy        (m_busy),
    .err         (m_err),
    .frames_done (m_frames_done)
  );

  // Every cycle: at most one strobe line, and none outside an expected frame.
  always @(negedge UserCLK) begin
    if (!reset) begin
      checks++;
      if ($countones(frame_strobe) > 1) begin
        errors++;
        $display("FAIL onehot: strobe=%h has %0d bits set, required <= 1", frame_strobe, $countones(frame_strobe));
      end
      checks++;
      if (!strobe_window && frame_strobe !== '0) begin
        errors++;
        $display("FAIL stray_strobe: strobe=%h outside a frame, required 0", frame_strobe);
      end
      checks++;
      if ($countones(m_strobe) > 1) begin
        errors++;
        $display("FAIL mini_onehot: strobe=%h, required <= 1 bit", m_strobe);
      end
      if (m_strobe != '0) m_strobe_cycles++;
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_hdr(input logic [7:0] sync, input logic [7:0] col, input logic [4:0] idx);
    return {sync, 8'($urandom), col, 3'($urandom), idx};
  endfunction

  function automatic logic [NR*W-1:0] rand_fd();
    logic [NR*W-1:0] v;
    for (int r = 0; r < NR; r++) v[r*W +: W] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    model_fd     = '0;
    model_frames = 0;
    model_err    = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [31:0] d, input int gap_max);
    int n;
    repeat ($urandom_range(gap_max)) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      @(negedge UserCLK);
    end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge UserCLK);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
    end
    @(negedge UserCLK);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic run_frame(input logic [31:0] hdr, input logic [NR*W-1:0] fd, input int gap_max, input string tag);
    logic [NC*MF-1:0] exp_strobe;
    send_word(hdr, gap_max);
    for (int r = 0; r < NR; r++) begin
      if (r == NR - 1) strobe_window = 1'b1;
      send_word(fd[r*W +: W], gap_max);
    end
    model_fd = fd;
    model_frames++;
    exp_strobe = '0;
    exp_strobe[int'(hdr[15:8]) * MF + int'(hdr[4:0])] = 1'b1;
    for (int k = 0; k < SL; k++) begin
      checks++;
      if (frame_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL %s strobe_cycle%0d: strobe=%h, required %h", tag, k, frame_strobe, exp_strobe);
      end
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s strobe_flags%0d: s_ready=%b busy=%b, required 0 1", tag, k, s_ready, busy);
      end
      checks++;
      if (frame_data !== model_fd) begin
        errors++;
        $display("FAIL %s data_in_strobe: FrameData=%h, required %h", tag, frame_data, model_fd);
      end
      @(negedge UserCLK);
    end
    checks++;
    if (frame_strobe !== '0 || s_ready !== 1'b0 || busy !== 1'b1 || frame_data !== model_fd) begin
      errors++;
      $display("FAIL %s gap: strobe=%h s_ready=%b busy=%b FrameData=%h, required 0 0 1 %h",
               tag, frame_strobe, s_ready, busy, frame_data, model_fd);
    end
    @(negedge UserCLK);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after: s_ready=%b busy=%b, required 1 0", tag, s_ready, busy);
    end
    checks++;
    if (frames_done !== 16'(model_frames)) begin
      errors++;
      $display("FAIL %s frames_done: got %0d, required %0d", tag, frames_done, 16'(model_frames));
    end
    checks++;
    if (frame_data !== model_fd || err !== model_err) begin
      errors++;
      $display("FAIL %s after_frame: FrameData=%h err=%b, required %h %b", tag, frame_data, err, model_fd, model_err);
    end
    strobe_window = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge UserCLK);
    reset   = 1'b0;
    @(negedge UserCLK);
    model_reset();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge UserCLK);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || frames_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags: s_ready=%b busy=%b err=%b frames_done=%0d, required 0 0 0 0", s_ready, busy, err, frames_done);
    end
    checks++;
    if (frame_data !== '0 || frame_strobe !== '0) begin
      errors++;
      $display("FAIL reset_outputs: FrameData=%h strobe=%h, required 0 0", frame_data, frame_strobe);
    end
    reset = 1'b0;
    @(negedge UserCLK);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b busy=%b, required 1 0", s_ready, busy);
    end
    model_reset();
  endtask

  task automatic test_directed_frame();
    run_frame(32'hA500_0203, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, "directed");
  endtask

  task automatic test_bad_sync();
    send_word(32'h5A00_0000, 0);
    model_err = 1'b1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_sync: err=%b busy=%b s_ready=%b, required 1 0 1", err, busy, s_ready);
    end
    repeat (3) @(negedge UserCLK);
    checks++;
    if (busy !== 1'b0 || frame_data !== model_fd) begin
      errors++;
      $display("FAIL bad_sync_idle: busy=%b FrameData=%h, required 0 %h", busy, frame_data, model_fd);
    end
    run_frame(mk_hdr(8'hA5, 8'($urandom_range(NC - 1)), 5'($urandom_range(MF - 1))), rand_fd(), 0, "after_bad_sync");
  endtask

  task automatic bad_range_case(input logic [31:0] hdr, input string tag);
    do_reset();
    send_word(hdr, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: err=%b busy=%b s_ready=%b, required 1 0 1", tag, err, busy, s_ready);
    end
    repeat (5) @(negedge UserCLK);
    checks++;
    if (frame_data !== '0 || frames_done !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: FrameData=%h frames_done=%0d busy=%b, required 0 0 0", tag, frame_data, frames_done, busy);
    end
  endtask

  task automatic test_bad_range();
    bad_range_case(mk_hdr(8'hA5, 8'd4, 5'($urandom_range(MF - 1))), "bad_col4");
    bad_range_case(mk_hdr(8'hA5, 8'($urandom_range(NC - 1)), 5'd20), "bad_idx20");
    bad_range_case(mk_hdr(8'hA5, 8'($urandom_range(255, 5)), 5'($urandom_range(31, 21))), "bad_both");
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [NR*W-1:0] fd;
    fd = rand_fd();
    run_frame(mk_hdr(8'hA5, 8'd0, 5'd0), fd, 0, "b2b_dense");
    run_frame(mk_hdr(8'hA5, 8'd3, 5'd19), fd, 3, "b2b_sparse");
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 10; i++) begin
      run_frame(mk_hdr(8'hA5, 8'($urandom_range(NC - 1)), 5'($urandom_range(MF - 1))),
                rand_fd(), $urandom_range(3), "random");
    end
  endtask

  task automatic test_reset_mid_load();
    send_word(mk_hdr(8'hA5, 8'd1, 5'd7), 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'hCAFE_F00D, 0);
    reset = 1'b1;
    @(negedge UserCLK);
    checks++;
    if (frame_data !== '0 || frame_strobe !== '0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: FrameData=%h strobe=%h s_ready=%b busy=%b, required 0 0 0 0",
               frame_data, frame_strobe, s_ready, busy);
    end
    reset = 1'b0;
    model_reset();
    repeat (6) @(negedge UserCLK);
    checks++;
    if (frame_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load_idle: FrameData=%h busy=%b, required 0 0", frame_data, busy);
    end
    run_frame(mk_hdr(8'hA5, 8'($urandom_range(NC - 1)), 5'($urandom_range(MF - 1))), rand_fd(), 1, "after_reset_load");
  endtask

  task automatic test_reset_mid_strobe();
    send_word(mk_hdr(8'hA5, 8'd2, 5'd11), 0);
    for (int r = 0; r < NR; r++) begin
      if (r == NR - 1) strobe_window = 1'b1;
      send_word($urandom, 0);
    end
    checks++;
    if (frame_strobe[2*MF + 11] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_strobe_pre: strobe=%h, required bit %0d high", frame_strobe, 2*MF + 11);
    end
    reset = 1'b1;
    @(negedge UserCLK);
    checks++;
    if (frame_strobe !== '0 || frame_data !== '0 || frames_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_strobe: strobe=%h FrameData=%h frames_done=%0d, required 0 0 0",
               frame_strobe, frame_data, frames_done);
    end
    reset = 1'b0;
    @(negedge UserCLK);
    strobe_window = 1'b0;
    model_reset();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_strobe_release: s_ready=%b busy=%b, required 1 0", s_ready, busy);
    end
  endtask

  // 65537 frames through the small instance: frames_done must wrap to 1.
  task automatic test_wrap();
    int  sent;
    int  n;
    bit  phase;
    bit  xfer;
    logic [31:0] last_word;
    sent = 0;
    n = 0;
    phase = 1'b0;
    last_word = '0;
    m_strobe_cycles = 0;
    m_valid = 1'b1;
    while (sent < 65537 && n < 300000) begin
      m_data = phase ? $urandom : mk_hdr(8'hA5, 8'($urandom_range(1)), 5'($urandom_range(3)));
      xfer = m_ready;
      @(negedge UserCLK);
      n++;
      if (xfer) begin
        if (phase) begin
          sent++;
          last_word = m_data;
        end
        phase = ~phase;
      end
    end
    m_valid = 1'b0;
    repeat (4) @(negedge UserCLK);
    checks++;
    if (sent != 65537) begin
      errors++;
      $display("FAIL wrap_budget: sent %0d frames, required 65537", sent);
    end
    checks++;
    if (m_frames_done !== 16'd1) begin
      errors++;
      $display("FAIL wrap_frames_done: got %0d, required 1", m_frames_done);
    end
    checks++;
    if (m_strobe_cycles != 65537) begin
      errors++;
      $display("FAIL wrap_strobe_cycles: got %0d, required 65537", m_strobe_cycles);
    end
    checks++;
    if (m_fd !== last_word || m_err !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_final: FrameData=%h err=%b busy=%b s_ready=%b, required %h 0 0 1",
               m_fd, m_err, m_busy, m_ready, last_word);
    end
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_bad_sync();
    test_bad_range();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_load();
    test_reset_mid_strobe();
    do_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
